axi4_rd_burst_track_multi: RTL and testbench

Synthesizable AXI4 read-channel protocol tracker for simulation and in-system debug. It passively observes AR and R handshakes and keeps an in-order queue of outstanding bursts (ID and length). It checks ID order, beat count against ARLEN, orphan beats, error responses, queue overflow and stalled bursts. Violations are reported as registered sticky flags with first-error capture, for connection to ILA, status registers or testbench monitors. It sits beside any AXI4 master/slave read pair and drives nothing on the bus.

---
 rtl/axi4_rd_burst_track_multi_if.sv | 31 +++
 rtl/axi4_rd_burst_track_multi.sv | 171 +++++++++++++++++
 tb/tb_axi4_rd_burst_track_multi.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_rd_burst_track_multi_if.sv
// rtl/axi4_rd_burst_track_multi_if.sv - mirrored AXI4 read address/data channel bundle
// Ports (as signals): arid, arlen, arvalid, arready (AR channel);
//                     rid, rresp, rlast, rvalid, rready (R channel).
// Modports: master/slave for the real bus ends, monitor for passive observers.
interface axi4_rd_burst_track_multi_if #(
  parameter int IDSIZE = 4
) ();
  logic [IDSIZE-1:0] arid;
  logic [7:0]        arlen;
  logic              arvalid;
  logic              arready;
  logic [IDSIZE-1:0] rid;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  modport master (
    output arid, arlen, arvalid, rready,
    input  arready, rid, rresp, rlast, rvalid
  );

  modport slave (
    input  arid, arlen, arvalid, rready,
    output arready, rid, rresp, rlast, rvalid
  );

  modport monitor (
    input arid, arlen, arvalid, arready, rid, rresp, rlast, rvalid, rready
  );
endinterface

// File: rtl/axi4_rd_burst_track_multi.sv
// rtl/axi4_rd_burst_track_multi.sv - passive AXI4 read burst tracker with sticky error flags
// Ports:
//   axi_aclk, axi_areset  clock, synchronous active-high reset
//   axi                   mirrored AR/R channel (monitor modport, inputs only)
//   err_clr               clears flags, first-error capture and stall timer
//   outstanding           bursts currently queued
//   err_*                 sticky violation flags, err_any = OR of them (registered)
//   err_first_code/id     first error seen since reset/err_clr and the ID involved
module axi4_rd_burst_track_multi #(
  parameter int IDSIZE     = 4,
  parameter int DEPTH      = 16,
  parameter int MAX_OUT    = 16,
  parameter int TIMEOUT    = 1000,
  parameter int CHECK_RESP = 1
) (
  input  logic                       axi_aclk,
  input  logic                       axi_areset,
  axi4_rd_burst_track_multi_if.monitor axi,
  input  logic                       err_clr,
  output logic [$clog2(DEPTH+1)-1:0] outstanding,
  output logic                       err_overflow,
  output logic                       err_orphan,
  output logic                       err_wrong_id,
  output logic                       err_bad_last,
  output logic                       err_resp,
  output logic                       err_timeout,
  output logic                       err_any,
  output logic [2:0]                 err_first_code,
  output logic [IDSIZE-1:0]          err_first_id
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  // Event/flag bit order doubles as first-error priority (bit 0 highest).
  localparam int E_OVF = 0, E_ORPH = 1, E_WID = 2, E_LAST = 3, E_RESP = 4, E_TO = 5;

  logic [IDSIZE-1:0] id_mem_q  [DEPTH];
  logic [IDSIZE-1:0] id_mem_d  [DEPTH];
  logic [7:0]        len_mem_q [DEPTH];
  logic [7:0]        len_mem_d [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [7:0]        beat_cnt_q, beat_cnt_d;
  logic [15:0]       to_cnt_q, to_cnt_d;
  logic              to_fired_q, to_fired_d;
  logic [5:0]        flags_q, flags_d;
  logic              err_any_q, err_any_d;
  logic [2:0]        code_q, code_d;
  logic [IDSIZE-1:0] fid_q, fid_d;

  logic              ar_hs, r_hs, empty, full, at_max, beat, pop, store;
  logic [IDSIZE-1:0] head_id;
  logic [7:0]        head_len;
  logic [5:0]        evt;

  assign ar_hs    = axi.arvalid && axi.arready;
  assign r_hs     = axi.rvalid && axi.rready;
  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == CW'(DEPTH));
  assign at_max   = (cnt_q == CW'(MAX_OUT));
  assign head_id  = id_mem_q[rd_ptr_q];
  assign head_len = len_mem_q[rd_ptr_q];
  // Beats while empty are orphans and never touch the queue, even if an AR lands this cycle.
  assign beat     = r_hs && !empty;
  assign pop      = beat && axi.rlast;
  // A full queue still accepts a push when the head pops in the same cycle.
  assign store    = ar_hs && (!full || pop);

  always_comb begin
    evt         = '0;
    evt[E_OVF]  = ar_hs && at_max && !pop;
    evt[E_ORPH] = r_hs && empty;
    evt[E_WID]  = beat && (axi.rid != head_id);
    evt[E_LAST] = beat && (axi.rlast ? (beat_cnt_q != head_len) : (beat_cnt_q == head_len));
    evt[E_RESP] = (CHECK_RESP != 0) && beat && axi.rresp[1];
    // Fires once per stall; the counter parks at TIMEOUT until a beat or clear.
    evt[E_TO]   = (to_cnt_q == 16'(TIMEOUT)) && !to_fired_q;
  end

  always_comb begin
    id_mem_d  = id_mem_q;
    len_mem_d = len_mem_q;
    if (store) begin
      id_mem_d[wr_ptr_q]  = axi.arid;
      len_mem_d[wr_ptr_q] = axi.arlen;
    end
    wr_ptr_d = wr_ptr_q + PW'(store);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    cnt_d    = cnt_q + CW'(store) - CW'(pop);

    beat_cnt_d = beat_cnt_q;
    if (pop) begin
      beat_cnt_d = '0;
    end else if (beat && (beat_cnt_q != 8'hFF)) begin
      beat_cnt_d = beat_cnt_q + 8'd1;
    end

    to_cnt_d   = to_cnt_q;
    to_fired_d = to_fired_q | evt[E_TO];
    if (err_clr || r_hs || empty) begin
      to_cnt_d   = '0;
      to_fired_d = 1'b0;
    end else if (to_cnt_q != 16'(TIMEOUT)) begin
      to_cnt_d = to_cnt_q + 16'd1;
    end

    // err_clr clears first, so an error in the same cycle still lands.
    flags_d   = (err_clr ? 6'd0 : flags_q) | evt;
    err_any_d = |flags_d;
    code_d    = err_clr ? 3'd0 : code_q;
    fid_d     = err_clr ? '0 : fid_q;
    if (code_d == 3'd0) begin
      if (evt[E_OVF]) begin
        code_d = 3'd1; fid_d = axi.arid;
      end else if (evt[E_ORPH]) begin
        code_d = 3'd2; fid_d = axi.rid;
      end else if (evt[E_WID]) begin
        code_d = 3'd3; fid_d = axi.rid;
      end else if (evt[E_LAST]) begin
        code_d = 3'd4; fid_d = axi.rid;
      end else if (evt[E_RESP]) begin
        code_d = 3'd5; fid_d = axi.rid;
      end else if (evt[E_TO]) begin
        code_d = 3'd6; fid_d = head_id;
      end
    end
  end

  // Queue storage needs no reset: entries are only read between push and pop.
  always_ff @(posedge axi_aclk) begin
    id_mem_q  <= id_mem_d;
    len_mem_q <= len_mem_d;
  end

  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      beat_cnt_q <= '0;
      to_cnt_q   <= '0;
      to_fired_q <= 1'b0;
      flags_q    <= '0;
      err_any_q  <= 1'b0;
      code_q     <= '0;
      fid_q      <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      beat_cnt_q <= beat_cnt_d;
      to_cnt_q   <= to_cnt_d;
      to_fired_q <= to_fired_d;
      flags_q    <= flags_d;
      err_any_q  <= err_any_d;
      code_q     <= code_d;
      fid_q      <= fid_d;
    end
  end

  assign outstanding    = cnt_q;
  assign err_overflow   = flags_q[E_OVF];
  assign err_orphan     = flags_q[E_ORPH];
  assign err_wrong_id   = flags_q[E_WID];
  assign err_bad_last   = flags_q[E_LAST];
  assign err_resp       = flags_q[E_RESP];
  assign err_timeout    = flags_q[E_TO];
  assign err_any        = err_any_q;
  assign err_first_code = code_q;
  assign err_first_id   = fid_q;
endmodule

// File: tb/tb_axi4_rd_burst_track_multi.sv
// tb/tb_axi4_rd_burst_track_multi.sv - directed bench with queue-based reference model
module tb_axi4_rd_burst_track_multi;
  localparam int IDW = 4;
  localparam int DEP = 4;
  localparam int MO  = 4;
  localparam int TO  = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic       err_clr;
  logic [2:0] outstanding;
  logic       err_overflow, err_orphan, err_wrong_id, err_bad_last, err_resp, err_timeout, err_any;
  logic [2:0] err_first_code;
  logic [IDW-1:0] err_first_id;

  always #5 clk = ~clk;

  axi4_rd_burst_track_multi_if #(.IDSIZE(IDW)) bus ();

  axi4_rd_burst_track_multi #(
    .IDSIZE(IDW), .DEPTH(DEP), .MAX_OUT(MO), .TIMEOUT(TO), .CHECK_RESP(1)
  ) dut (
    .axi_aclk(clk), .axi_areset(rst), .axi(bus), .err_clr(err_clr),
    .outstanding(outstanding), .err_overflow(err_overflow), .err_orphan(err_orphan),
    .err_wrong_id(err_wrong_id), .err_bad_last(err_bad_last), .err_resp(err_resp),
    .err_timeout(err_timeout), .err_any(err_any), .err_first_code(err_first_code),
    .err_first_id(err_first_id)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: list of open bursts, beat index in head burst, stall length.
  typedef struct { int id; int len; } ent_t;
  ent_t mq[$];
  int   m_bc, m_stall, m_code, m_id;
  logic [5:0] m_flags;
  bit   m_started = 0;

  always @(posedge clk) begin : model
    bit ar, r, emp, beat, pop;
    int sz, head;
    logic [5:0] e;
    m_started = 1;
    if (rst) begin
      mq.delete();
      m_bc = 0; m_stall = 0; m_flags = '0; m_code = 0; m_id = 0;
    end else begin
      ar   = bus.arvalid && bus.arready;
      r    = bus.rvalid && bus.rready;
      sz   = mq.size();
      emp  = (sz == 0);
      head = emp ? 0 : mq[0].id;
      e    = '0;
      beat = r && !emp;
      pop  = beat && bus.rlast;
      if (r && emp) e[1] = 1'b1;
      if (beat) begin
        if (int'(bus.rid) != mq[0].id) e[2] = 1'b1;
        // rlast must appear on exactly the beat numbered len
        if (bus.rlast != (m_bc == mq[0].len)) e[3] = 1'b1;
        if (bus.rresp[1]) e[4] = 1'b1;
      end
      if (ar && sz == MO && !pop) e[0] = 1'b1;
      if (m_stall == TO) e[5] = 1'b1;
      if (err_clr || r || emp) m_stall = 0; else m_stall++;
      if (pop) begin
        void'(mq.pop_front());
        m_bc = 0;
      end else if (beat && m_bc < 255) begin
        m_bc++;
      end
      if (ar && !(sz == DEP && !pop)) mq.push_back('{int'(bus.arid), int'(bus.arlen)});
      if (err_clr) begin
        m_flags = '0; m_code = 0; m_id = 0;
      end
      m_flags |= e;
      if (m_code == 0) begin
        for (int k = 0; k < 6; k++) begin
          if (e[k] && m_code == 0) begin
            m_code = k + 1;
            m_id   = (k == 0) ? int'(bus.arid) : (k == 5) ? head : int'(bus.rid);
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_started) begin
      chk("outstanding", outstanding, mq.size());
      chk("err_overflow", err_overflow, m_flags[0]);
      chk("err_orphan", err_orphan, m_flags[1]);
      chk("err_wrong_id", err_wrong_id, m_flags[2]);
      chk("err_bad_last", err_bad_last, m_flags[3]);
      chk("err_resp", err_resp, m_flags[4]);
      chk("err_timeout", err_timeout, m_flags[5]);
      chk("err_any", err_any, |m_flags);
      chk("err_first_code", err_first_code, m_code);
      chk("err_first_id", err_first_id, m_id);
    end
  end

  task automatic idle_in();
    bus.arid = '0; bus.arlen = '0; bus.arvalid = 0; bus.arready = 0;
    bus.rid = '0; bus.rresp = '0; bus.rlast = 0; bus.rvalid = 0; bus.rready = 0;
    err_clr = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle_in();
  endtask

  task automatic ar(input int id, input int len);
    bus.arvalid = 1; bus.arready = 1; bus.arid = IDW'(id); bus.arlen = 8'(len);
  endtask

  task automatic rb(input int id, input bit last, input logic [1:0] resp);
    bus.rvalid = 1; bus.rready = 1; bus.rid = IDW'(id); bus.rlast = last; bus.rresp = resp;
  endtask

  task automatic clr();
    err_clr = 1;
    tick();
  endtask

  initial begin
    idle_in();
    rst = 1;
    repeat (2) tick();
    rst = 0;
    tick();
    chk("rst_outstanding", outstanding, 0);
    chk("rst_err_any", err_any, 0);
    chk("rst_code", err_first_code, 0);
    chk("rst_id", err_first_id, 0);

    // Clean 4-beat burst; AR without arready is not a push
    bus.arvalid = 1; bus.arid = 4'd3;
    tick();
    chk("ar_no_ready", outstanding, 0);
    ar(3, 3); tick();
    chk("t1_out1", outstanding, 1);
    for (int i = 0; i < 4; i++) begin
      rb(3, i == 3, 2'b00); tick();
    end
    chk("t1_out0", outstanding, 0);
    chk("t1_clean", err_any, 0);

    // Out-of-order ID
    ar(1, 0); tick();
    ar(2, 0); tick();
    rb(2, 1, 2'b00); tick();
    chk("t2_wrong_id", err_wrong_id, 1);
    chk("t2_code", err_first_code, 3);
    chk("t2_id", err_first_id, 2);
    rb(1, 1, 2'b00); tick();
    chk("t2_out0", outstanding, 0);
    clr();
    chk("t2_clr_any", err_any, 0);
    chk("t2_clr_code", err_first_code, 0);

    // Early last pops the burst
    ar(5, 3); tick();
    rb(5, 0, 2'b00); tick();
    rb(5, 1, 2'b00); tick();
    chk("t3_early", err_bad_last, 1);
    chk("t3_early_code", err_first_code, 4);
    chk("t3_early_out", outstanding, 0);
    clr();
    // Missing last on beat index len
    ar(6, 1); tick();
    rb(6, 0, 2'b00); tick();
    chk("t3_beat1_ok", err_bad_last, 0);
    rb(6, 0, 2'b00); tick();
    chk("t3_missing", err_bad_last, 1);
    rb(6, 1, 2'b00); tick();
    chk("t3_out0", outstanding, 0);
    clr();

    // Overflow at MAX_OUT == DEPTH, entry dropped
    for (int i = 0; i < 4; i++) begin
      ar(i, 0); tick();
    end
    chk("t4_full", outstanding, 4);
    chk("t4_no_ovf_yet", err_overflow, 0);
    ar(9, 0); tick();
    chk("t4_ovf", err_overflow, 1);
    chk("t4_ovf_out", outstanding, 4);
    chk("t4_ovf_code", err_first_code, 1);
    chk("t4_ovf_id", err_first_id, 9);
    for (int i = 0; i < 4; i++) begin
      rb(i, 1, 2'b00); tick();
    end
    chk("t4_drained", outstanding, 0);
    chk("t4_drop_ok", err_wrong_id, 0);
    clr();
    // Same push+pop while full is legal
    for (int i = 0; i < 4; i++) begin
      ar(i, 0); tick();
    end
    ar(4, 0); rb(0, 1, 2'b00); tick();
    chk("t4b_no_ovf", err_any, 0);
    chk("t4b_out", outstanding, 4);
    for (int i = 1; i < 5; i++) begin
      rb(i, 1, 2'b00); tick();
    end
    chk("t4b_drained", outstanding, 0);
    chk("t4b_clean", err_any, 0);

    // Timeout exactly TO+1 cycles after the AR handshake
    ar(7, 0); tick();
    repeat (TO) tick();
    chk("t5_not_yet", err_timeout, 0);
    tick();
    chk("t5_timeout", err_timeout, 1);
    chk("t5_code", err_first_code, 6);
    chk("t5_id", err_first_id, 7);
    rb(7, 1, 2'b00); tick();
    chk("t5_out0", outstanding, 0);
    err_clr = 1; rb(3, 1, 2'b00); tick();
    chk("t5_orphan", err_orphan, 1);
    chk("t5_to_clr", err_timeout, 0);
    chk("t5_code2", err_first_code, 2);
    chk("t5_id2", err_first_id, 3);
    clr();

    // Error response, then reset mid-burst
    ar(9, 3); tick();
    rb(9, 0, 2'b10); tick();
    chk("t6_resp", err_resp, 1);
    chk("t6_code", err_first_code, 5);
    rb(9, 0, 2'b00); tick();
    rst = 1; tick();
    rst = 0;
    chk("t6_rst_out", outstanding, 0);
    chk("t6_rst_any", err_any, 0);
    rb(9, 0, 2'b00); tick();
    chk("t6_orphan", err_orphan, 1);
    chk("t6_orphan_code", err_first_code, 2);
    chk("t6_orphan_id", err_first_id, 9);
    rb(9, 1, 2'b00); tick();
    chk("t6_out0", outstanding, 0);

    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
